// File: rtl/order_book_pkg.sv
// Shared types and constants for the add-order front end.
// Command bundle, response codes, book markers and FSM states.
package order_book_pkg;

  localparam int ORDER_W = 16;

  localparam logic SIDE_BUY  = 1'b0;
  localparam logic SIDE_SELL = 1'b1;

  localparam logic [1:0] RSP_OK   = 2'd0;
  localparam logic [1:0] RSP_FULL = 2'd1;
  localparam logic [1:0] RSP_REJ  = 2'd2;

  localparam logic [ORDER_W-1:0] EMPTY_WORD = 16'h0000;
  localparam logic [ORDER_W-1:0] DELETED_ID = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_RELEASE,
    ST_RESPOND
  } seq_state_t;

  typedef struct packed {
    logic               side;
    logic [ORDER_W-1:0] id;
    logic [ORDER_W-1:0] size;
    logic [ORDER_W-1:0] limit;
  } order_cmd_t;

  // Zero and all-ones words mark empty/deleted book slots,
  // so such commands can never be written.
  function automatic logic cmd_ok(input order_cmd_t c);
    return !(c.id == EMPTY_WORD ||
             c.id == DELETED_ID ||
             c.size == EMPTY_WORD ||
             c.limit == EMPTY_WORD);
  endfunction

endpackage

// File: rtl/order_add_sequencer_if.sv
// Command, add-engine and response buses of the sequencer.
// slave = sequencer side, master = environment side.
interface order_add_sequencer_if;
  import order_book_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_side;
  logic [ORDER_W-1:0] cmd_id;
  logic [ORDER_W-1:0] cmd_size;
  logic [ORDER_W-1:0] cmd_limit;

  logic               add_start;
  logic               add_side;
  logic [ORDER_W-1:0] add_id;
  logic [ORDER_W-1:0] add_size;
  logic [ORDER_W-1:0] add_limit;
  logic [ORDER_W-1:0] add_success;
  logic               add_done;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [ORDER_W-1:0] rsp_id;
  logic [1:0]         rsp_code;

  modport slave (
    input  cmd_valid, cmd_side, cmd_id,
    input  cmd_size, cmd_limit,
    output cmd_ready,
    output add_start, add_side, add_id,
    output add_size, add_limit,
    input  add_success, add_done,
    output rsp_valid, rsp_id, rsp_code,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_side, cmd_id,
    output cmd_size, cmd_limit,
    input  cmd_ready,
    input  add_start, add_side, add_id,
    input  add_size, add_limit,
    output add_success, add_done,
    input  rsp_valid, rsp_id, rsp_code,
    output rsp_ready
  );

endinterface

// File: rtl/order_cmd_fifo.sv
// Synchronous command FIFO, wrap-bit pointers for full/empty.
// Ports: clk, rst, i_push/i_data, i_pop/o_data, o_full, o_empty.
module order_cmd_fifo
  import order_book_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  order_cmd_t i_data,
  input  logic       i_pop,
  output order_cmd_t o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam logic [PTR_W:0] PTR_ONE =
    {{PTR_W{1'b0}}, 1'b1};

  order_cmd_t     r_mem [DEPTH];
  logic [PTR_W:0] r_wr;
  logic [PTR_W:0] r_rd;
  logic           w_we;
  logic           w_re;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[PTR_W] != r_rd[PTR_W]) &&
                   (r_wr[PTR_W-1:0] == r_rd[PTR_W-1:0]);

  assign w_we = i_push & ~o_full;
  assign w_re = i_pop & ~o_empty;

  assign o_data = r_mem[r_rd[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr[PTR_W-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_we) r_wr <= r_wr + PTR_ONE;
      if (w_re) r_rd <= r_rd + PTR_ONE;
    end
  end

endmodule

// File: rtl/order_add_sequencer.sv
// Add-order front end: buffers, validates and issues commands.
// Ports: clk, rst, bus (cmd/add/rsp), cnt_ok/cnt_full/cnt_rej.
module order_add_sequencer
  import order_book_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  order_add_sequencer_if.slave  bus,
  output logic [CNT_W-1:0]      cnt_ok,
  output logic [CNT_W-1:0]      cnt_full,
  output logic [CNT_W-1:0]      cnt_rej
);

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  seq_state_t         r_state;
  seq_state_t         w_next;
  order_cmd_t         r_hold;
  order_cmd_t         w_cmd_in;
  order_cmd_t         w_head;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_hold_ok;
  logic               w_rsp_hs;
  logic               w_add_start;
  logic               w_rsp_valid;
  logic [1:0]         r_code;
  logic               r_add_side;
  logic [ORDER_W-1:0] r_add_id;
  logic [ORDER_W-1:0] r_add_size;
  logic [ORDER_W-1:0] r_add_limit;
  logic [CNT_W-1:0]   r_cnt_ok;
  logic [CNT_W-1:0]   r_cnt_full;
  logic [CNT_W-1:0]   r_cnt_rej;

  assign w_cmd_in = {bus.cmd_side, bus.cmd_id,
                     bus.cmd_size, bus.cmd_limit};
  assign w_push   = bus.cmd_valid & ~w_full;
  assign w_pop    = (r_state == ST_IDLE) & ~w_empty;
  assign w_hold_ok = cmd_ok(r_hold);
  assign w_rsp_hs = (r_state == ST_RESPOND) & bus.rsp_ready;

  order_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (!w_empty) w_next = ST_CHECK;
      ST_CHECK:
        w_next = w_hold_ok ? ST_ISSUE : ST_RESPOND;
      ST_ISSUE:
        if (bus.add_done) w_next = ST_RELEASE;
      // engine must be back idle before the next issue
      ST_RELEASE:
        if (!bus.add_done) w_next = ST_RESPOND;
      ST_RESPOND:
        if (bus.rsp_ready) w_next = ST_IDLE;
      default:
        w_next = ST_IDLE;
    endcase
  end

  // start/valid decode straight from state so reset
  // clears them without waiting for a clock
  always_comb begin
    w_add_start = (r_state == ST_ISSUE);
    w_rsp_valid = (r_state == ST_RESPOND);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold      <= '0;
      r_code      <= RSP_OK;
      r_add_side  <= SIDE_BUY;
      r_add_id    <= EMPTY_WORD;
      r_add_size  <= EMPTY_WORD;
      r_add_limit <= EMPTY_WORD;
    end else begin
      if (w_pop) r_hold <= w_head;
      if (r_state == ST_CHECK) begin
        if (w_hold_ok) begin
          r_add_side  <= r_hold.side;
          r_add_id    <= r_hold.id;
          r_add_size  <= r_hold.size;
          r_add_limit <= r_hold.limit;
        end else begin
          r_code <= RSP_REJ;
        end
      end
      if (r_state == ST_ISSUE && bus.add_done) begin
        r_code <= (bus.add_success != '0) ?
                  RSP_OK : RSP_FULL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_ok   <= '0;
      r_cnt_full <= '0;
      r_cnt_rej  <= '0;
    end else if (w_rsp_hs) begin
      case (r_code)
        RSP_OK:
          if (r_cnt_ok != '1)
            r_cnt_ok <= r_cnt_ok + CNT_ONE;
        RSP_FULL:
          if (r_cnt_full != '1)
            r_cnt_full <= r_cnt_full + CNT_ONE;
        RSP_REJ:
          if (r_cnt_rej != '1)
            r_cnt_rej <= r_cnt_rej + CNT_ONE;
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = ~w_full;
  assign bus.add_start = w_add_start;
  assign bus.add_side  = r_add_side;
  assign bus.add_id    = r_add_id;
  assign bus.add_size  = r_add_size;
  assign bus.add_limit = r_add_limit;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_id    = r_hold.id;
  assign bus.rsp_code  = r_code;

  assign cnt_ok   = r_cnt_ok;
  assign cnt_full = r_cnt_full;
  assign cnt_rej  = r_cnt_rej;

endmodule

// File: doc/order_add_sequencer.md
Name: order_add_sequencer

Overview:
- Upstream front end of the add-order engine.
- Accepts order commands on a valid/ready input, buffers them in a small FIFO, and validates each one.
- Drives the add engine's start/side/id/size/limit interface using a 4-phase start/done handshake, and returns one response per command with its outcome.
- Keeps saturating counters of accepted, book-full and rejected commands.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; must be a power of two, minimum 2.
- PTR_W, 2, log2(FIFO_DEPTH).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full; a transfer occurs when cmd_valid and cmd_ready are both high.
- cmd_side  in  1  0 = buy, 1 = sell.
- cmd_id  in  16  order id.
- cmd_size  in  16  order quantity.
- cmd_limit  in  16  limit price.
- add_start  out  1  start to the add engine.
- add_side  out  1  side to the add engine.
- add_id  out  16  id to the add engine.
- add_size  out  16  size to the add engine.
- add_limit  out  16  limit to the add engine.
- add_success  in  16  nonzero means the order was written into the book.
- add_done  in  1  add engine finished; stays high until add_start falls.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response accepted.
- rsp_id  out  16  id of the command this response answers.
- rsp_code  out  2  0 = OK, 1 = BOOK_FULL, 2 = REJECT, 3 = unused.
- cnt_ok  out  CNT_W  count of OK responses.
- cnt_full  out  CNT_W  count of BOOK_FULL responses.
- cnt_rej  out  CNT_W  count of REJECT responses.

Behaviour:
Reset (rst low, asynchronous):
- State goes to IDLE; FIFO is emptied; pointers go to 0.
- add_start=0, rsp_valid=0, rsp_code=0, rsp_id=0, all counters=0.
- add_side/id/size/limit reset to 0.
- cmd_ready=1 once reset is released.

FIFO:
- Write on a cmd transfer; read (pop) in IDLE when the FIFO is non-empty.
- Full/empty are detected with PTR_W+1-bit pointers; the MSB is the wrap flag.
- cmd_ready = !full, driven combinationally from registered pointers.
- A push and a pop in the same cycle are both honoured and the occupancy is unchanged.
- A push while full is impossible because cmd_ready is low.

State machine:
- IDLE: if the FIFO is non-empty, pop the head into holding registers, then go to CHECK.
- CHECK: validate the held command.
  - Reject if id==0, id==16'hFFFF, size==0, or limit==0. Zero and all-ones words are the book's empty/deleted markers. Reject sets rsp_code=2 and goes to RESPOND.
  - Otherwise load add_side/id/size/limit from the holding registers and go to ISSUE.
- ISSUE: add_start=1, with all add_* data held stable.
  - Wait for add_done=1.
  - On that edge, latch the code: 0 if add_success!=0, else 1. Drop add_start and go to RELEASE.
- RELEASE: add_start=0; wait for add_done=0, then go to RESPOND. This guarantees the engine is back in IDLE before any new issue.
- RESPOND: rsp_valid=1, rsp_id = held id, rsp_code = latched code.
  - When rsp_ready=1: drop rsp_valid, increment the matching counter, go to IDLE.

Latency:
- A reject response is valid 2 cycles after the pop cycle (IDLE -> CHECK -> RESPOND).
- An accepted command raises add_start 2 cycles after the pop.
- Minimum occupancy per command is IDLE + CHECK + ISSUE + RELEASE + RESPOND = 5 cycles, plus engine time.

Counters:
- Each counter saturates at all-ones and never wraps.
- Exactly one counter increments per response handshake.

Ordering and backpressure:
- Responses are returned strictly in command order; only one command is in flight at a time.
- rsp_ready low stalls the FSM in RESPOND. The FIFO keeps accepting commands until it is full.
- While in RESPOND, rsp_id and rsp_code stay stable until the handshake completes.

Boundary cases:
- add_done already high on entry to ISSUE cannot happen, because RELEASE waits for it to fall.
- rsp_ready is sampled only in RESPOND.
- Reset mid-ISSUE forces add_start=0 immediately. The add engine shares the same reset.

Decomposition:
- Shared package (order_book_pkg):
  - ORDER_W=16.
  - SIDE_BUY=0, SIDE_SELL=1.
  - RSP_OK=2'd0, RSP_FULL=2'd1, RSP_REJ=2'd2.
  - EMPTY_WORD=0, DELETED_ID=16'hFFFF.
  - FSM state encodings.
- One sub-module: order_cmd_fifo, a synchronous FIFO with 49-bit data (side, id, size, limit), parameterised by FIFO_DEPTH, with full/empty outputs.

Test Plan:
- Single valid buy (side=0, id=5, size=100, limit=250); engine stub returns success=1 after 8 cycles -> add_start high 2 cycles after the pop, holding id=5/size=100/limit=250; response rsp_id=5, code=0; cnt_ok=1.
- Command id=0, size=10 -> add_start never rises; response code=2 two cycles after the pop; cnt_rej=1.
- Command id=16'hFFFF, then command id=7 with size=0 -> two REJECT responses in order (ids 16'hFFFF, then 7).
- Book full: stub returns success=0 for id=9 -> response code=1; cnt_full=1; add_start stays low until add_done falls.
- Burst of 6 commands with rsp_ready held low -> cmd_ready falls after 4 are buffered plus 1 held. Release rsp_ready -> all 6 responses come back in order, ids matching.
- Assert rst low during ISSUE -> add_start=0 and rsp_valid=0 asynchronously; FIFO empty; counters 0; cmd_ready=1 after reset is released.
